// File: rtl/ahb5_to_apb4_bridge.sv
// rtl/ahb5_to_apb4_bridge.sv - AHB5 subordinate that turns each single AHB beat into one APB4 transfer
module ahb5_to_apb4_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HNONSEC,
    input  logic                  HMASTLOCK,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        accept;
    logic        illegal;
    logic [3:0]  strb_d;
    logic        hreadyout_d;
    logic        hresp_d;
    logic        psel_d;
    logic        penable_d;
    logic        unused_inputs;

    assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT[3:2], HTRANS[0]};

    // ERR2 already drives HREADYOUT=1, so it can take the next address phase like IDLE
    assign accept  = HSEL && HREADY && HTRANS[1] && ((state == S_IDLE) || (state == S_ERR2));
    assign illegal = (HSIZE > 3'd2)
                  || ((HSIZE == 3'd1) && HADDR[0])
                  || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    always_comb begin
        strb_d = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    strb_d = 4'b0001 << HADDR[1:0];
                3'd1:    strb_d = 4'b0011 << {HADDR[1], 1'b0};
                default: strb_d = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    if (illegal)     state_d = S_ERR1;
                    else if (HWRITE) state_d = S_WDATA;
                    else             state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WDATA:  state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (PREADY) state_d = PSLVERR ? S_ERR1 : S_IDLE;
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = S_IDLE;
        endcase
        // Outputs are decoded from the next state so they leave the flops aligned with it
        hreadyout_d = (state_d == S_IDLE) || (state_d == S_ERR2);
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
        psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d   = (state_d == S_ACCESS);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
        end else begin
            state     <= state_d;
            HREADYOUT <= hreadyout_d;
            HRESP     <= hresp_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
        end
    end

    // Captured fields only change on accept, which keeps them stable through SETUP and ACCESS
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PSTRB  <= 4'b0000;
            PPROT  <= 3'b000;
            PWDATA <= 32'h0;
            HRDATA <= 32'h0;
        end else begin
            if (accept) begin
                PADDR  <= HADDR[ADDR_WIDTH-1:0];
                PWRITE <= HWRITE;
                PSTRB  <= strb_d;
                PPROT  <= {~HPROT[0], HNONSEC, HPROT[1]};
            end
            if (state == S_WDATA) begin
                PWDATA <= HWDATA;
            end
            if ((state == S_ACCESS) && PREADY && !PWRITE) begin
                HRDATA <= PRDATA;
            end
        end
    end

endmodule
